// File: rtl/kpu_pkg.sv
// ---------------------------------------------------------------------------
// kpu_pkg
//   Shared types and constants for the kpu front end.
//   fetch_state_t : fetch FSM states (IDLE, REQ)
//   FETCH_STEP    : byte increment of the PC per opword
//   BUS_WIDTH     : width of the shared datapath bus and of an opword
//   word_align()  : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package kpu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    localparam int FETCH_STEP = 4;
    localparam int BUS_WIDTH  = 32;

    function automatic logic [BUS_WIDTH-1:0] word_align(input logic [BUS_WIDTH-1:0] addr);
        return {addr[BUS_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory read handshake between the fetch unit and memory.
//   mem_addr  : byte address of the requested opword (fetch -> memory)
//   mem_n_rd  : read request, active low            (fetch -> memory)
//   mem_rdy   : read data valid this cycle          (memory -> fetch)
//   mem_data  : read data                           (memory -> fetch)
//   Modports: master = fetch unit, slave = memory.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_n_rd;
    logic                  mem_rdy;
    logic [31:0]           mem_data;

    modport master (
        output mem_addr,
        output mem_n_rd,
        input  mem_rdy,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_n_rd,
        output mem_rdy,
        output mem_data
    );
endinterface

// File: rtl/fetch_prefetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_buf
//   One-entry holding register for an opword fetched ahead of demand.
//   Used by fetch_unit only when FETCH_PREFETCH_EN is defined.
//   clk, n_rst : clock, asynchronous active-low reset
//   flush      : discard the entry (highest priority)
//   load       : capture load_data and mark the entry full
//   consume    : the entry has been handed over; mark it empty
//   data, full : stored opword and its occupancy flag
// ---------------------------------------------------------------------------
module fetch_prefetch_buf
    import kpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 flush,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] load_data,
    input  logic                 consume,
    output logic [BUS_WIDTH-1:0] data,
    output logic                 full
);
    logic [BUS_WIDTH-1:0] data_reg;
    logic                 full_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (flush) begin
            full_reg <= 1'b0;
        end else if (load) begin
            data_reg <= load_data;
            full_reg <= 1'b1;
        end else if (consume) begin
            full_reg <= 1'b0;
        end
    end

    assign data = data_reg;
    assign full = full_reg;
endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage ahead of the kpu core datapath. Holds the PC,
//   reads opwords over the mem handshake and drives the opword or the PC
//   onto the shared bus under the control-logic output enables.
//   Optional feature macro: FETCH_PREFETCH_EN (one-entry prefetch buffer).
//
//   clk          : clock, rising edge
//   n_rst        : asynchronous active-low reset
//   fetch        : start a fetch of the opword at PC
//   pc_load      : load PC from bus_in (word aligned), priority over all
//   bus_in       : shared bus value sampled on pc_load
//   mem          : fetch_unit_if.master memory read port
//   opword_n_out : drive OPWORD on bus_out when low
//   pc_n_out     : drive zero-extended PC on bus_out when low
//   bus_out      : shared bus driver, high impedance when not enabled
//   opword_valid : OPWORD holds a completed fetch
//   busy         : memory request outstanding
//   misalign     : last pc_load had nonzero byte-offset bits
// ---------------------------------------------------------------------------
module fetch_unit
    import kpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
)(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 fetch,
    input  logic                 pc_load,
    input  logic [BUS_WIDTH-1:0] bus_in,
    fetch_unit_if.master         mem,
    input  logic                 opword_n_out,
    input  logic                 pc_n_out,
    output logic [BUS_WIDTH-1:0] bus_out,
    output logic                 opword_valid,
    output logic                 busy,
    output logic                 misalign
);
    fetch_state_t          state_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic                  mem_n_rd_reg;
    logic [BUS_WIDTH-1:0]  opword_reg;
    logic                  opword_valid_reg;
    logic                  busy_reg;
    logic                  misalign_reg;

    logic [ADDR_WIDTH-1:0] pc_loaded;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [BUS_WIDTH-1:0]  bus_in_aligned;
    logic                  unused_bus_bits;

    assign bus_in_aligned  = word_align(bus_in);
    assign pc_loaded       = bus_in_aligned[ADDR_WIDTH-1:0];
    // Wraps modulo 2^ADDR_WIDTH by plain truncation.
    assign pc_inc          = pc_reg + ADDR_WIDTH'(FETCH_STEP);
    assign unused_bus_bits = &{1'b0, bus_in_aligned[BUS_WIDTH-1:ADDR_WIDTH]};

`ifdef FETCH_PREFETCH_EN
    // pf_reg marks the outstanding request as a speculative read of the
    // word at PC; its data goes to the buffer instead of OPWORD.
    logic                 pf_reg;
    logic [BUS_WIDTH-1:0] buf_data;
    logic                 buf_full;
    logic                 buf_load;
    logic                 buf_consume;

    // A fetch arriving with the prefetch still in flight turns it into a
    // demand read, so the returning data then bypasses the buffer.
    assign buf_load    = !pc_load && (state_reg == REQ) && pf_reg && mem.mem_rdy && !fetch;
    assign buf_consume = !pc_load && (state_reg == IDLE) && fetch && buf_full;

    fetch_prefetch_buf u_prefetch_buf (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (pc_load),
        .load      (buf_load),
        .load_data (mem.mem_data),
        .consume   (buf_consume),
        .data      (buf_data),
        .full      (buf_full)
    );
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg        <= IDLE;
            pc_reg           <= RESET_PC;
            mem_addr_reg     <= RESET_PC;
            mem_n_rd_reg     <= 1'b1;
            opword_reg       <= '0;
            opword_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            misalign_reg     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_reg           <= 1'b0;
`endif
        end else if (pc_load) begin
            // A jump kills any outstanding read; a same-edge fetch goes
            // straight out at the new address.
            pc_reg           <= pc_loaded;
            misalign_reg     <= |bus_in[1:0];
            opword_valid_reg <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_reg           <= 1'b0;
`endif
            if (fetch) begin
                state_reg    <= REQ;
                mem_addr_reg <= pc_loaded;
                mem_n_rd_reg <= 1'b0;
                busy_reg     <= 1'b1;
            end else begin
                state_reg    <= IDLE;
                mem_n_rd_reg <= 1'b1;
                busy_reg     <= 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fetch) begin
`ifdef FETCH_PREFETCH_EN
                        if (buf_full) begin
                            // Serve from the buffer and prefetch the next word.
                            opword_reg       <= buf_data;
                            opword_valid_reg <= 1'b1;
                            pc_reg           <= pc_inc;
                            mem_addr_reg     <= pc_inc;
                            pf_reg           <= 1'b1;
                        end else begin
                            mem_addr_reg     <= pc_reg;
                            opword_valid_reg <= 1'b0;
                            pf_reg           <= 1'b0;
                        end
`else
                        mem_addr_reg     <= pc_reg;
                        opword_valid_reg <= 1'b0;
`endif
                        state_reg    <= REQ;
                        mem_n_rd_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                REQ: begin
`ifdef FETCH_PREFETCH_EN
                    if (mem.mem_rdy) begin
                        if (pf_reg && !fetch) begin
                            // Prefetched word parked in the buffer.
                            state_reg    <= IDLE;
                            mem_n_rd_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            pf_reg       <= 1'b0;
                        end else begin
                            // Demand read done; request stays open for the next word.
                            opword_reg       <= mem.mem_data;
                            opword_valid_reg <= 1'b1;
                            pc_reg           <= pc_inc;
                            mem_addr_reg     <= pc_inc;
                            pf_reg           <= 1'b1;
                        end
                    end else if (fetch && pf_reg) begin
                        pf_reg           <= 1'b0;
                        opword_valid_reg <= 1'b0;
                    end
`else
                    if (mem.mem_rdy) begin
                        opword_reg       <= mem.mem_data;
                        opword_valid_reg <= 1'b1;
                        pc_reg           <= pc_inc;
                        state_reg        <= IDLE;
                        mem_n_rd_reg     <= 1'b1;
                        busy_reg         <= 1'b0;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem.mem_addr = mem_addr_reg;
    assign mem.mem_n_rd = mem_n_rd_reg;
    assign opword_valid = opword_valid_reg;
    assign busy         = busy_reg;
    assign misalign     = misalign_reg;

    // Opword enable wins if control logic ever asserts both.
    assign bus_out = !opword_n_out ? opword_reg :
                     !pc_n_out     ? BUS_WIDTH'(pc_reg) :
                                     {BUS_WIDTH{1'bz}};

    // Both output enables low at once is a control-logic error.
    assert property (@(posedge clk) disable iff (!n_rst) !(!opword_n_out && !pc_n_out));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import kpu_pkg::*;

    localparam int AW = 24;

    logic        clk          = 1'b0;
    logic        n_rst        = 1'b0;
    logic        fetch        = 1'b0;
    logic        pc_load      = 1'b0;
    logic [31:0] bus_in       = '0;
    logic        opword_n_out = 1'b1;
    logic        pc_n_out     = 1'b1;
    logic [31:0] bus_out;
    logic        opword_valid;
    logic        busy;
    logic        misalign;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    fetch_unit_if #(.ADDR_WIDTH(AW)) mif ();

    fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .fetch        (fetch),
        .pc_load      (pc_load),
        .bus_in       (bus_in),
        .mem          (mif.master),
        .opword_n_out (opword_n_out),
        .pc_n_out     (pc_n_out),
        .bus_out      (bus_out),
        .opword_valid (opword_valid),
        .busy         (busy),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Settle one unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_bus(input logic sel_pc, output logic [31:0] v);
        opword_n_out = sel_pc;
        pc_n_out     = !sel_pc;
        #1;
        v = bus_out;
        opword_n_out = 1'b1;
        pc_n_out     = 1'b1;
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        read_bus(1'b1, v);
        check(tag, v, exp);
    endtask

    task automatic check_opword(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        read_bus(1'b0, v);
        check(tag, v, exp);
    endtask

    // Scoreboard pop: the next completed opword must match the oldest push.
    task automatic pop_opword(input string tag);
        logic [31:0] v;
        logic [31:0] e;
        check({tag, "_valid"}, 32'(opword_valid), 32'd1);
        read_bus(1'b0, v);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, v);
        end else begin
            e = exp_q.pop_front();
            check(tag, v, e);
        end
    endtask

    task automatic mem_respond(input logic [31:0] data, input bit expect_it);
        mif.mem_rdy  = 1'b1;
        mif.mem_data = data;
        if (expect_it) exp_q.push_back(data);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_n_rd"},  32'(mif.mem_n_rd), 32'd1);
        check({tag, "_addr"},  32'(mif.mem_addr), 32'd0);
        check({tag, "_valid"}, 32'(opword_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_mis"},   32'(misalign),     32'd0);
        check_pc({tag, "_pc"}, 32'd0);
        check_opword({tag, "_op"}, 32'd0);
    endtask

    initial begin
        mif.mem_rdy  = 1'b0;
        mif.mem_data = '0;

        // Reset
        tick();
        tick();
        check_reset_state("reset");
        n_rst = 1'b1;
        $display("step reset released");

`ifdef FETCH_PREFETCH_EN
        // Two back-to-back fetches; the second is served from the buffer.
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("pf1_n_rd", 32'(mif.mem_n_rd), 32'd0);
        check("pf1_addr", 32'(mif.mem_addr), 32'd0);
        mem_respond(32'hAAAA_0001, 1'b1);
        tick();
        mif.mem_rdy = 1'b0;
        pop_opword("pf1_op");
        check("pf1_pref_n_rd", 32'(mif.mem_n_rd), 32'd0);
        check("pf1_pref_addr", 32'(mif.mem_addr), 32'd4);
        $display("step prefetch first word");
        mem_respond(32'hBBBB_0002, 1'b1);
        tick();
        mif.mem_rdy = 1'b0;
        check("pf_buf_n_rd", 32'(mif.mem_n_rd), 32'd1);
        check("pf_buf_busy", 32'(busy), 32'd0);
        check_opword("pf_buf_op_hold", 32'hAAAA_0001);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        pop_opword("pf2_op");
        check_pc("pf2_pc", 32'd8);
        check("pf2_addr", 32'(mif.mem_addr), 32'd8);
        check("pf2_n_rd", 32'(mif.mem_n_rd), 32'd0);
        $display("step prefetch second word from buffer");
`else
        // Fetch with a three-cycle memory wait
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("f1_n_rd", 32'(mif.mem_n_rd), 32'd0);
        check("f1_busy", 32'(busy), 32'd1);
        check("f1_addr", 32'(mif.mem_addr), 32'd0);
        tick();
        tick();
        check("f1_wait_valid", 32'(opword_valid), 32'd0);
        check("f1_wait_n_rd", 32'(mif.mem_n_rd), 32'd0);
        mem_respond(32'hDEAD_BEEF, 1'b1);
        tick();
        mif.mem_rdy = 1'b0;
        pop_opword("f1_op");
        check("f1_done_n_rd", 32'(mif.mem_n_rd), 32'd1);
        check("f1_done_busy", 32'(busy), 32'd0);
        check_pc("f1_pc", 32'd4);
        $display("step fetch DEADBEEF");

        // Memory ready while idle is ignored
        mem_respond(32'h1234_5678, 1'b0);
        tick();
        mif.mem_rdy = 1'b0;
        check("idle_rdy_valid", 32'(opword_valid), 32'd1);
        check_opword("idle_rdy_op", 32'hDEAD_BEEF);
        check_pc("idle_rdy_pc", 32'd4);
        $display("step ready while idle");

        // Misaligned PC load
        pc_load = 1'b1;
        bus_in  = 32'h0000_1236;
        tick();
        pc_load = 1'b0;
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_valid", 32'(opword_valid), 32'd0);
        check_pc("mis_pc", 32'h0000_1234);
        $display("step pc_load 00001236");

        // Load + fetch same edge at the top of the address space; PC wraps
        pc_load = 1'b1;
        fetch   = 1'b1;
        bus_in  = 32'h00FF_FFFC;
        tick();
        pc_load = 1'b0;
        fetch   = 1'b0;
        check("wrap_addr", 32'(mif.mem_addr), 32'h00FF_FFFC);
        check("wrap_n_rd", 32'(mif.mem_n_rd), 32'd0);
        check("wrap_mis", 32'(misalign), 32'd0);
        mem_respond(32'hCAFE_F00D, 1'b1);
        tick();
        mif.mem_rdy = 1'b0;
        pop_opword("wrap_op");
        check_pc("wrap_pc", 32'd0);
        $display("step pc wrap");

        // Jump during an outstanding read discards the returning data
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("abort_n_rd0", 32'(mif.mem_n_rd), 32'd0);
        check("abort_valid0", 32'(opword_valid), 32'd0);
        tick();
        pc_load = 1'b1;
        bus_in  = 32'h0000_0100;
        tick();
        pc_load = 1'b0;
        check("abort_n_rd", 32'(mif.mem_n_rd), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        mem_respond(32'hBAAD_F00D, 1'b0);
        tick();
        mif.mem_rdy = 1'b0;
        check("abort_valid", 32'(opword_valid), 32'd0);
        check_pc("abort_pc", 32'h0000_0100);
        check_opword("abort_op", 32'hCAFE_F00D);
        $display("step abort by pc_load");
`endif

        // Asynchronous reset mid-request
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        check("rst_pre_n_rd", 32'(mif.mem_n_rd), 32'd0);
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_state("rst_async");
        tick();
        n_rst = 1'b1;
        tick();
        check("rst_after_n_rd", 32'(mif.mem_n_rd), 32'd1);
        $display("step async reset");

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
